// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: table geometry, index hash and the
// committed-update record exchanged between the ROB side and the predictor.
package bp_pkg;

    localparam int BTB_SIZE  = 64;
    localparam int PRIME     = 337;
    localparam int BTB_IDX_W = $clog2(BTB_SIZE);

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } upd_entry_t;

    // Must stay identical to the index computation inside branch_target_buffer.
    function automatic logic [BTB_IDX_W-1:0] bp_hash(input logic [31:0] pc);
        logic [31:0] prod;
        prod = pc * 32'(PRIME);
        return prod[BTB_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO of committed branch outcomes with head peek; push on full
// and pop on empty are ignored so the caller may strobe unconditionally.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         push,
    input  logic [31:0]                  wr_pc,
    input  logic                         wr_taken,
    input  logic                         pop,
    output logic [31:0]                  head_pc,
    output logic                         head_taken,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    upd_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign head_pc    = mem[rd_ptr].pc;
    assign head_taken = mem[rd_ptr].taken;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count alone says which slots
    // hold live entries, so stale contents are never observed.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= '{pc: wr_pc, taken: wr_taken};
    end

endmodule

// File: rtl/btb_update_scheduler.sv
// Arbitrates IF lookups and committed ROB updates onto branch_target_buffer,
// deferring an update that hits the same table index as a same-cycle lookup.
module btb_update_scheduler
    import bp_pkg::*;
#(
    parameter int UPD_DEPTH = 4,
    parameter int MAX_DEFER = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              rdy_in,
    input  logic                              flush_in,
    input  logic                              lookup_req,
    input  logic [31:0]                       lookup_pc,
    output logic                              pred_valid,
    output logic [31:0]                       pred_pc,
    output logic                              pred_taken,
    input  logic                              upd_valid,
    input  logic [31:0]                       upd_pc,
    input  logic                              upd_taken,
    output logic                              upd_ready,
    output logic                              btb_judge,
    output logic [31:0]                       btb_judge_pc,
    output logic                              btb_change,
    output logic [31:0]                       btb_change_pc,
    output logic                              btb_result,
    input  logic                              btb_jump_in,
    output logic [$clog2(UPD_DEPTH+1)-1:0]    upd_count
);

    localparam int DEF_W = $clog2(MAX_DEFER + 1);

    logic               active;
    logic               fifo_full;
    logic               fifo_empty;
    logic [31:0]        head_pc;
    logic               head_taken;
    logic               collide;
    logic               issue;
    logic               push;
    logic [DEF_W-1:0]   defer_cnt;
    logic               resp_pend;
    logic [31:0]        resp_pc;

    // Strobes are held low while frozen or in reset so the predictor sees no traffic.
    assign active       = rdy_in & rst_n_in;
    assign btb_judge    = lookup_req & active;
    assign btb_judge_pc = rst_n_in ? lookup_pc : '0;

    assign collide = btb_judge
                   & (bp_hash(head_pc) == bp_hash(lookup_pc))
                   & (defer_cnt < DEF_W'(MAX_DEFER));
    assign issue   = active & ~fifo_empty & ~collide;

    assign btb_change    = issue;
    assign btb_change_pc = issue ? head_pc : '0;
    assign btb_result    = issue & head_taken;

    assign upd_ready = active & ~fifo_full;
    assign push      = upd_valid & upd_ready;

    assign pred_valid = resp_pend & rdy_in & ~flush_in;
    assign pred_pc    = resp_pc;
    assign pred_taken = pred_valid & btb_jump_in;

    bp_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .push       (push),
        .wr_pc      (upd_pc),
        .wr_taken   (upd_taken),
        .pop        (issue),
        .head_pc    (head_pc),
        .head_taken (head_taken),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (upd_count)
    );

    // A flush in the issue cycle cancels the response before it is ever raised.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            resp_pend <= 1'b0;
            resp_pc   <= '0;
            defer_cnt <= '0;
        end else if (rdy_in) begin
            resp_pend <= btb_judge & ~flush_in;
            if (btb_judge) resp_pc <= lookup_pc;
            if (fifo_empty || !collide) defer_cnt <= '0;
            else                        defer_cnt <= defer_cnt + DEF_W'(1);
        end
    end

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Self-checking bench for btb_update_scheduler: hand-derived vector table,
// directed fill/reset sequences, and randomized traffic against a queue model.
module tb_btb_update_scheduler;

    localparam int DEPTH  = 4;
    localparam int NDEFER = 2;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b0, flush_in = 1'b0;
    logic        lookup_req = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_pc;
    logic        upd_valid = 1'b0, upd_taken = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_ready;
    logic        btb_judge, btb_change, btb_result;
    logic [31:0] btb_judge_pc, btb_change_pc;
    logic        btb_jump_in = 1'b0;
    logic [2:0]  upd_count;

    always #5 clk_in = ~clk_in;

    btb_update_scheduler #(.UPD_DEPTH(DEPTH), .MAX_DEFER(NDEFER)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .lookup_req(lookup_req), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .btb_judge(btb_judge), .btb_judge_pc(btb_judge_pc),
        .btb_change(btb_change), .btb_change_pc(btb_change_pc), .btb_result(btb_result),
        .btb_jump_in(btb_jump_in), .upd_count(upd_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic taken; } m_entry_t;
    m_entry_t    m_q[$];
    int          m_defer;
    bit          m_resp_pend;
    logic [31:0] m_resp_pc;

    bit          e_judge, e_ready, e_collide, e_change, e_res, e_pv, e_pt;
    logic [31:0] e_cpc;
    int          e_cnt;

    function automatic int ref_idx(input logic [31:0] pc);
        return int'((64'(pc) * 64'd337) % 64'd64);
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_defer = 0;
        m_resp_pend = 0;
        m_resp_pc = '0;
    endfunction

    function automatic void model_eval();
        e_judge   = lookup_req && rdy_in;
        e_ready   = rdy_in && (m_q.size() < DEPTH);
        e_collide = e_judge && (m_q.size() > 0) &&
                    (ref_idx(m_q[0].pc) == ref_idx(lookup_pc)) && (m_defer < NDEFER);
        e_change  = rdy_in && (m_q.size() > 0) && !e_collide;
        e_cpc     = e_change ? m_q[0].pc : 32'h0;
        e_res     = e_change ? m_q[0].taken : 1'b0;
        e_pv      = rdy_in && m_resp_pend && !flush_in;
        e_pt      = e_pv && btb_jump_in;
        e_cnt     = m_q.size();
    endfunction

    task automatic compare_model(input string tag);
        model_eval();
        check({tag, ".judge"},     btb_judge,       e_judge);
        check({tag, ".judge_pc"},  btb_judge_pc,    lookup_pc);
        check({tag, ".change"},    btb_change,      e_change);
        check({tag, ".change_pc"}, btb_change_pc,   e_cpc);
        check({tag, ".result"},    btb_result,      e_res);
        check({tag, ".ready"},     upd_ready,       e_ready);
        check({tag, ".count"},     32'(upd_count),  32'(e_cnt));
        check({tag, ".pred_valid"}, pred_valid,     e_pv);
        check({tag, ".pred_taken"}, pred_taken,     e_pt);
        if (e_pv) check({tag, ".pred_pc"}, pred_pc, m_resp_pc);
    endtask

    // Advance one clock; the model consumes the inputs that were stable across the edge.
    task automatic tick();
        bit had;
        model_eval();
        had = m_q.size() > 0;
        @(posedge clk_in);
        if (rdy_in) begin
            if (e_change) void'(m_q.pop_front());
            if (upd_valid && e_ready) m_q.push_back('{pc: upd_pc, taken: upd_taken});
            if (!had || !e_collide) m_defer = 0;
            else                    m_defer++;
            m_resp_pend = e_judge && !flush_in;
            if (e_judge) m_resp_pc = lookup_pc;
        end
        #1;
    endtask

    task automatic drive(input bit rdy, input bit fl, input bit lr, input logic [31:0] lpc,
                         input bit uv, input logic [31:0] upc, input bit ut, input bit jmp);
        rdy_in = rdy; flush_in = fl; lookup_req = lr; lookup_pc = lpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; btb_jump_in = jmp;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit rdy, fl, lr; logic [31:0] lpc; bit uv; logic [31:0] upc; bit ut, jmp;
        bit e_judge, e_change; logic [31:0] e_cpc; bit e_res, e_ready; int e_cnt;
        bit e_pv; logic [31:0] e_ppc; bit e_pt;
    } vec_t;

    vec_t tbl[23];

    initial begin
        m_entry_t fill_q[6];
        int k;
        bit acc;

        // rdy fl lr lpc       uv upc        ut jmp | judge chg cpc    res rdy cnt pv ppc     pt
        tbl[0]  = '{1,0,0,32'h0,   0,32'h0,   0,0,  0,0,32'h0, 0,1,0, 0,32'h0,  0};
        tbl[1]  = '{1,0,1,32'h100, 0,32'h0,   0,0,  1,0,32'h0, 0,1,0, 0,32'h0,  0};
        tbl[2]  = '{1,0,0,32'h0,   0,32'h0,   0,1,  0,0,32'h0, 0,1,0, 1,32'h100,1};
        tbl[3]  = '{1,0,1,32'h100, 0,32'h0,   0,0,  1,0,32'h0, 0,1,0, 0,32'h0,  0};
        tbl[4]  = '{1,1,0,32'h0,   0,32'h0,   0,1,  0,0,32'h0, 0,1,0, 0,32'h0,  0};
        tbl[5]  = '{1,1,1,32'h200, 0,32'h0,   0,0,  1,0,32'h0, 0,1,0, 0,32'h0,  0};
        tbl[6]  = '{1,0,0,32'h0,   0,32'h0,   0,1,  0,0,32'h0, 0,1,0, 0,32'h0,  0};
        tbl[7]  = '{1,0,0,32'h0,   1,32'h0,   1,0,  0,0,32'h0, 0,1,0, 0,32'h0,  0};
        tbl[8]  = '{1,0,1,32'h40,  0,32'h0,   0,0,  1,0,32'h0, 0,1,1, 0,32'h0,  0};
        tbl[9]  = '{1,0,1,32'h40,  0,32'h0,   0,0,  1,0,32'h0, 0,1,1, 1,32'h40, 0};
        tbl[10] = '{1,0,1,32'h40,  0,32'h0,   0,1,  1,1,32'h0, 1,1,1, 1,32'h40, 1};
        tbl[11] = '{1,0,1,32'h40,  0,32'h0,   0,0,  1,0,32'h0, 0,1,0, 1,32'h40, 0};
        tbl[12] = '{1,0,0,32'h0,   1,32'h4,   0,0,  0,0,32'h0, 0,1,0, 1,32'h40, 0};
        tbl[13] = '{1,0,1,32'h0,   1,32'h8,   1,0,  1,1,32'h4, 0,1,1, 0,32'h0,  0};
        tbl[14] = '{1,0,0,32'h0,   0,32'h0,   0,1,  0,1,32'h8, 1,1,1, 1,32'h0,  1};
        tbl[15] = '{1,0,0,32'h0,   1,32'h0,   1,0,  0,0,32'h0, 0,1,0, 0,32'h0,  0};
        tbl[16] = '{1,0,1,32'h80,  1,32'h40,  0,0,  1,0,32'h0, 0,1,1, 0,32'h0,  0};
        tbl[17] = '{0,0,1,32'h80,  1,32'h999, 1,1,  0,0,32'h0, 0,0,2, 0,32'h0,  0};
        tbl[18] = '{0,0,1,32'h80,  1,32'h999, 1,1,  0,0,32'h0, 0,0,2, 0,32'h0,  0};
        tbl[19] = '{0,0,1,32'h80,  1,32'h999, 1,1,  0,0,32'h0, 0,0,2, 0,32'h0,  0};
        tbl[20] = '{1,0,0,32'h0,   0,32'h0,   0,1,  0,1,32'h0, 1,1,2, 1,32'h80, 1};
        tbl[21] = '{1,0,0,32'h0,   0,32'h0,   0,0,  0,1,32'h40,0,1,1, 0,32'h0,  0};
        tbl[22] = '{1,0,0,32'h0,   0,32'h0,   0,0,  0,0,32'h0, 0,1,0, 0,32'h0,  0};

        model_reset();
        drive(1, 0, 1, 32'h100, 1, 32'h0, 0, 0);
        #2;
        check("rst.pred_valid", pred_valid, 0);
        check("rst.judge",      btb_judge,  0);
        check("rst.change",     btb_change, 0);
        check("rst.ready",      upd_ready,  0);
        check("rst.count",      32'(upd_count), 0);
        repeat (2) @(posedge clk_in);
        #1;
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        rst_n_in = 1'b1;

        for (int i = 0; i < 23; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].rdy, tbl[i].fl, tbl[i].lr, tbl[i].lpc,
                  tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].jmp);
            #2;
            check({t, ".judge"},  btb_judge,  tbl[i].e_judge);
            check({t, ".change"}, btb_change, tbl[i].e_change);
            if (tbl[i].e_change) begin
                check({t, ".change_pc"}, btb_change_pc, tbl[i].e_cpc);
                check({t, ".result"},    btb_result,    tbl[i].e_res);
            end
            check({t, ".ready"},      upd_ready,       tbl[i].e_ready);
            check({t, ".count"},      32'(upd_count),  32'(tbl[i].e_cnt));
            check({t, ".pred_valid"}, pred_valid,      tbl[i].e_pv);
            check({t, ".pred_taken"}, pred_taken,      tbl[i].e_pt);
            if (tbl[i].e_pv) check({t, ".pred_pc"}, pred_pc, tbl[i].e_ppc);
            tick();
        end

        // Fill while every head collides with the lookup: full at count 4, sixth update held.
        for (int i = 0; i < 6; i++) fill_q[i] = '{pc: 32'(i) << 6, taken: 1'(i & 1)};
        k = 0;
        for (int c = 1; c <= 8; c++) begin
            drive(1, 0, 1, 32'h0, k < 6, (k < 6) ? fill_q[k].pc : 32'h0,
                  (k < 6) ? fill_q[k].taken : 1'b0, 0);
            #2;
            compare_model($sformatf("fill%0d", c));
            if (c == 6) begin
                check("fill.full_ready", upd_ready, 0);
                check("fill.full_count", 32'(upd_count), 4);
            end
            acc = upd_valid && upd_ready;
            tick();
            if (acc) k++;
        end
        check("fill.all_accepted", k, 6);

        // One plain drain cycle brings count to 3, then reset lands mid-cycle.
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        #2;
        compare_model("drain");
        tick();
        check("pre_rst.count", 32'(upd_count), 3);
        drive(1, 0, 1, 32'h40, 1, 32'h80, 1, 1);
        #2;
        rst_n_in = 1'b0;
        model_reset();
        #1;
        check("mid_rst.pred_valid", pred_valid,     0);
        check("mid_rst.pred_taken", pred_taken,     0);
        check("mid_rst.pred_pc",    pred_pc,        0);
        check("mid_rst.judge",      btb_judge,      0);
        check("mid_rst.judge_pc",   btb_judge_pc,   0);
        check("mid_rst.change",     btb_change,     0);
        check("mid_rst.change_pc",  btb_change_pc,  0);
        check("mid_rst.result",     btb_result,     0);
        check("mid_rst.ready",      upd_ready,      0);
        check("mid_rst.count",      32'(upd_count), 0);
        @(posedge clk_in);
        #1;
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        rst_n_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            check("post_rst.no_change", btb_change, 0);
            compare_model("post_rst");
            tick();
        end
        drive(1, 0, 0, 32'h0, 1, 32'h1234, 1, 0);
        #2;
        compare_model("post_rst.push");
        tick();
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        #2;
        check("post_rst.new_change", btb_change, 1);
        compare_model("post_rst.drain");
        tick();

        // Randomized traffic with PCs clustered so index collisions are common.
        for (int c = 0; c < 600; c++) begin
            logic [31:0] lpc, upc;
            lpc = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 15)) << 4);
            upc = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 15)) << 4);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)), lpc,
                  $urandom_range(0, 9) < 6, upc, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            #2;
            compare_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
